// File: rtl/audio_pkg.sv
// Shared audio-path constants and types.
package audio_pkg;
  localparam int SAMPLE_W      = 16;
  localparam int I2S_BCK_DIV   = 4;
  localparam int I2S_SLOT_BITS = 32;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  // Index into the packed {R, L} sample pairs.
  typedef enum logic {
    CH_L = 1'b0,
    CH_R = 1'b1
  } ch_e;
endpackage

// File: rtl/i2s_clkgen.sv
// I2S timing generator: prescaler, SCK, BCK, slot bit counter and LCK.
module i2s_clkgen #(
  parameter int BCK_DIV   = audio_pkg::I2S_BCK_DIV,
  parameter int SLOT_BITS = audio_pkg::I2S_SLOT_BITS,
  parameter int CNT_W     = $clog2(2*SLOT_BITS)
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             en_i,
  output logic             sck_o,
  output logic             bck_o,
  output logic             lck_o,
  output logic             bck_fall_o,
  output logic             frame_wrap_o,
  output logic [CNT_W-1:0] bit_cnt_o
);
  localparam int PW = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;

  logic [PW-1:0]    presc_q, presc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sck_q, bck_q, lck_q;
  logic             presc_wrap;

  assign presc_wrap   = presc_q == PW'(BCK_DIV-1);
  assign bck_fall_o   = en_i & presc_wrap & bck_q;
  assign frame_wrap_o = bck_fall_o & (cnt_q == CNT_W'(2*SLOT_BITS-1));

  always_comb begin
    presc_d = presc_wrap ? '0 : presc_q + PW'(1);
    cnt_d   = frame_wrap_o ? '0 : cnt_q + CNT_W'(1);
  end

  // ENABLE low parks everything in the reset state, even mid-frame.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      presc_q <= '0;
      cnt_q   <= '0;
      sck_q   <= 1'b0;
      bck_q   <= 1'b0;
      lck_q   <= 1'b0;
    end else if (!en_i) begin
      presc_q <= '0;
      cnt_q   <= '0;
      sck_q   <= 1'b0;
      bck_q   <= 1'b0;
      lck_q   <= 1'b0;
    end else begin
      sck_q   <= ~sck_q;
      presc_q <= presc_d;
      if (presc_wrap) bck_q <= ~bck_q;
      if (bck_fall_o) begin
        cnt_q <= cnt_d;
        lck_q <= cnt_d >= CNT_W'(SLOT_BITS);
      end
    end
  end

  assign sck_o     = sck_q;
  assign bck_o     = bck_q;
  assign lck_o     = lck_q;
  assign bit_cnt_o = cnt_q;
endmodule

// File: rtl/i2s_tx_stereo.sv
// Stereo I2S master transmitter: one-deep holding buffer, L/R shift registers,
// DIN serialiser and overrun/underrun flags.
module i2s_tx_stereo #(
  parameter int SAMPLE_W  = audio_pkg::SAMPLE_W,
  parameter int BCK_DIV   = audio_pkg::I2S_BCK_DIV,
  parameter int SLOT_BITS = audio_pkg::I2S_SLOT_BITS
) (
  input  logic                CLK,
  input  logic                RSTn,
  input  logic                ENABLE,
  input  logic [SAMPLE_W-1:0] SMP_L,
  input  logic [SAMPLE_W-1:0] SMP_R,
  input  logic                SMP_VALID,
  output logic                SCK,
  output logic                BCK,
  output logic                LCK,
  output logic                DIN,
  output logic                FRAME_STB,
  output logic                OVERRUN,
  output logic                UNDERRUN
);
  import audio_pkg::*;

  localparam int CNT_W = $clog2(2*SLOT_BITS);

  logic             bck_fall, frame_wrap;
  logic [CNT_W-1:0] bit_cnt;

  i2s_clkgen #(
    .BCK_DIV  (BCK_DIV),
    .SLOT_BITS(SLOT_BITS),
    .CNT_W    (CNT_W)
  ) u_clkgen (
    .CLK         (CLK),
    .RSTn        (RSTn),
    .en_i        (ENABLE),
    .sck_o       (SCK),
    .bck_o       (BCK),
    .lck_o       (LCK),
    .bck_fall_o  (bck_fall),
    .frame_wrap_o(frame_wrap),
    .bit_cnt_o   (bit_cnt)
  );

  logic [1:0][SAMPLE_W-1:0] hold_q, hold_d, sreg_q, sreg_d;
  logic                     hold_full_q, hold_full_d;
  logic                     din_q, din_d;
  logic                     stb_q, ovr_q, und_q;
  logic [CNT_W-1:0]         cnt_nxt, pos_nxt;
  logic                     ch_nxt;
  logic                     cap;

  assign cap = ENABLE & SMP_VALID;

  // DIN is computed for the slot position bit_cnt moves to on this edge.
  always_comb begin
    cnt_nxt     = frame_wrap ? '0 : bit_cnt + CNT_W'(1);
    ch_nxt      = cnt_nxt >= CNT_W'(SLOT_BITS);
    pos_nxt     = ch_nxt ? cnt_nxt - CNT_W'(SLOT_BITS) : cnt_nxt;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    sreg_d      = sreg_q;
    din_d       = din_q;
    if (frame_wrap) begin
      sreg_d      = hold_q;
      hold_full_d = 1'b0;
    end
    // A capture coinciding with a load lands after the load took the old data.
    if (cap) begin
      hold_d[CH_L] = SMP_L;
      hold_d[CH_R] = SMP_R;
      hold_full_d  = 1'b1;
    end
    if (bck_fall) begin
      din_d = 1'b0;
      if (pos_nxt >= CNT_W'(1) && pos_nxt <= CNT_W'(SAMPLE_W)) begin
        din_d          = sreg_q[ch_nxt][SAMPLE_W-1];
        sreg_d[ch_nxt] = {sreg_q[ch_nxt][SAMPLE_W-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      hold_q      <= '0;
      sreg_q      <= '0;
      hold_full_q <= 1'b0;
      din_q       <= 1'b0;
      stb_q       <= 1'b0;
      ovr_q       <= 1'b0;
      und_q       <= 1'b0;
    end else if (!ENABLE) begin
      hold_q      <= '0;
      sreg_q      <= '0;
      hold_full_q <= 1'b0;
      din_q       <= 1'b0;
      stb_q       <= 1'b0;
      ovr_q       <= 1'b0;
      und_q       <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      sreg_q      <= sreg_d;
      hold_full_q <= hold_full_d;
      din_q       <= din_d;
      stb_q       <= frame_wrap;
      und_q       <= frame_wrap & ~hold_full_q;
      ovr_q       <= cap & hold_full_q & ~frame_wrap;
    end
  end

  assign DIN       = din_q;
  assign FRAME_STB = stb_q;
  assign OVERRUN   = ovr_q;
  assign UNDERRUN  = und_q;
endmodule
